// File: rtl/ft_mailbox.sv
// Dual-core fault-tolerant mailbox: each core posts a result and a flag into its
// own bank; once both cores have flagged, the results are compared.
module ft_mailbox #(
    parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i_1,
    input  logic        data_we_i_1,
    input  logic [3:0]  data_be_i_1,
    input  logic [31:0] data_addr_i_1,
    input  logic [31:0] data_wdata_i_1,
    output logic        data_gnt_o_1,
    output logic        data_rvalid_o_1,
    output logic [31:0] data_rdata_o_1,
    input  logic        data_req_i_2,
    input  logic        data_we_i_2,
    input  logic [3:0]  data_be_i_2,
    input  logic [31:0] data_addr_i_2,
    input  logic [31:0] data_wdata_i_2,
    output logic        data_gnt_o_2,
    output logic        data_rvalid_o_2,
    output logic [31:0] data_rdata_o_2,
    output logic [31:0] mem_flag,
    output logic [31:0] mem_result
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ONE      = 3'd1,
        S_DONE     = 3'd2,
        S_MISMATCH = 3'd3,
        S_TIMEOUT  = 3'd4
    } state_e;

    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];

    assign req      = {data_req_i_2, data_req_i_1};
    assign we       = {data_we_i_2, data_we_i_1};
    assign be[0]    = data_be_i_1;
    assign be[1]    = data_be_i_2;
    assign addr[0]  = data_addr_i_1;
    assign addr[1]  = data_addr_i_2;
    assign wdata[0] = data_wdata_i_1;
    assign wdata[1] = data_wdata_i_2;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{data_addr_i_1[1:0], data_addr_i_2[1:0]};

    state_e      state_q, state_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] result_q [2];
    logic [31:0] result_d [2];
    logic [31:0] flag_q   [2];
    logic [31:0] flag_d   [2];
    logic [1:0]  done_q, done_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata_q  [2];
    logic [31:0] rdata_d  [2];
    logic [31:0] mflag_q, mflag_d;
    logic [31:0] mres_q, mres_d;
    logic [31:0] status;

    assign status = {27'b0, state_q, done_q[1], done_q[0]};

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  ben);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (ben[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Bank access: each port only ever sees its own bank.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            logic sel;
            result_d[k] = result_q[k];
            flag_d[k]   = flag_q[k];
            rvalid_d[k] = req[k];
            rdata_d[k]  = '0;
            sel = req[k] && (addr[k][31:4] == BASE_ADDR[31:4]);
            if (sel && !we[k]) begin
                unique case (addr[k][3:2])
                    2'd0:    rdata_d[k] = result_q[k];
                    2'd1:    rdata_d[k] = flag_q[k];
                    2'd2:    rdata_d[k] = status;
                    default: rdata_d[k] = cycles_q;
                endcase
            end
            if (sel && we[k] && !done_q[k]) begin
                if (addr[k][3:2] == 2'd0)
                    result_d[k] = merge(result_q[k], wdata[k], be[k]);
                if (addr[k][3:2] == 2'd1)
                    flag_d[k] = merge(flag_q[k], wdata[k], be[k]);
            end
            done_d[k] = done_q[k] | (flag_d[k] != 32'd0);
        end
    end

    // Completion is judged on registered done bits and wins over timeout.
    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        unique case (state_q)
            S_IDLE, S_ONE: begin
                if (&done_q) begin
                    state_d = (result_q[0] == result_q[1]) ? S_DONE
                                                           : S_MISMATCH;
                end else if (cycles_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d = S_TIMEOUT;
                end else begin
                    state_d = (|done_q) ? S_ONE : S_IDLE;
                    if (cycles_q != 32'hFFFF_FFFF)
                        cycles_d = cycles_q + 32'd1;
                end
            end
            default: state_d = state_q;
        endcase
        mflag_d = {29'b0, state_d == S_TIMEOUT,
                   state_d == S_MISMATCH, state_d == S_DONE};
        mres_d  = (state_d == S_DONE) ? result_q[0] : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cycles_q <= '0;
            done_q   <= '0;
            rvalid_q <= '0;
            mflag_q  <= '0;
            mres_q   <= '0;
            for (int k = 0; k < 2; k++) begin
                result_q[k] <= '0;
                flag_q[k]   <= '0;
                rdata_q[k]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            mflag_q  <= mflag_d;
            mres_q   <= mres_d;
            for (int k = 0; k < 2; k++) begin
                result_q[k] <= result_d[k];
                flag_q[k]   <= flag_d[k];
                rdata_q[k]  <= rdata_d[k];
            end
        end
    end

    assign data_gnt_o_1    = data_req_i_1;
    assign data_gnt_o_2    = data_req_i_2;
    assign data_rvalid_o_1 = rvalid_q[0];
    assign data_rvalid_o_2 = rvalid_q[1];
    assign data_rdata_o_1  = rdata_q[0];
    assign data_rdata_o_2  = rdata_q[1];
    assign mem_flag        = mflag_q;
    assign mem_result      = mres_q;

endmodule

// File: tb/tb_ft_mailbox.sv
// Directed vector bench for ft_mailbox: bank access, compare outcomes,
// reset behaviour and timeout on a second short-timeout instance.
module tb_ft_mailbox;

    localparam logic [31:0] B   = 32'h0010_0000;
    localparam logic [31:0] RES = B + 32'h0;
    localparam logic [31:0] FLG = B + 32'h4;
    localparam logic [31:0] STA = B + 32'h8;
    localparam logic [31:0] CYC = B + 32'hC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        r1, w1, r2, w2;
    logic [3:0]  b1, b2;
    logic [31:0] a1, d1, a2, d2;
    logic        g1, g2, v1, v2;
    logic [31:0] q1, q2, mf, mr;

    ft_mailbox dut (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i_1(r1), .data_we_i_1(w1), .data_be_i_1(b1),
        .data_addr_i_1(a1), .data_wdata_i_1(d1),
        .data_gnt_o_1(g1), .data_rvalid_o_1(v1), .data_rdata_o_1(q1),
        .data_req_i_2(r2), .data_we_i_2(w2), .data_be_i_2(b2),
        .data_addr_i_2(a2), .data_wdata_i_2(d2),
        .data_gnt_o_2(g2), .data_rvalid_o_2(v2), .data_rdata_o_2(q2),
        .mem_flag(mf), .mem_result(mr)
    );

    logic        tr, tw;
    logic [31:0] ta;
    logic        zr = 1'b0;
    logic [3:0]  zb = 4'h0;
    logic [31:0] zw = 32'h0;
    logic        tg, tv, tg2, tv2;
    logic [31:0] tq, tq2, tmf, tmr;

    ft_mailbox #(.TIMEOUT_CYCLES(32'd50)) dut_to (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i_1(tr), .data_we_i_1(tw), .data_be_i_1(zb),
        .data_addr_i_1(ta), .data_wdata_i_1(zw),
        .data_gnt_o_1(tg), .data_rvalid_o_1(tv), .data_rdata_o_1(tq),
        .data_req_i_2(zr), .data_we_i_2(zr), .data_be_i_2(zb),
        .data_addr_i_2(zw), .data_wdata_i_2(zw),
        .data_gnt_o_2(tg2), .data_rvalid_o_2(tv2), .data_rdata_o_2(tq2),
        .mem_flag(tmf), .mem_result(tmr)
    );

    typedef struct packed {
        logic        r;
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;

    typedef struct {
        op_t         p1;
        op_t         p2;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] xf;
        logic [31:0] xr;
    } vec_t;

    int n_chk = 0;
    int n_miss = 0;
    vec_t tq_v[$];

    function automatic op_t NOP();
        return '{r: 1'b0, w: 1'b0, b: 4'h0, a: 32'h0, d: 32'h0};
    endfunction
    function automatic op_t RD(input logic [31:0] a);
        return '{r: 1'b1, w: 1'b0, b: 4'h0, a: a, d: 32'h0};
    endfunction
    function automatic op_t WR(input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d);
        return '{r: 1'b1, w: 1'b1, b: b, a: a, d: d};
    endfunction
    function automatic vec_t V(input op_t p1, input op_t p2,
                               input logic [31:0] x1, input logic [31:0] x2,
                               input logic [31:0] xf, input logic [31:0] xr);
        vec_t v;
        v.p1 = p1; v.p2 = p2; v.x1 = x1; v.x2 = x2; v.xf = xf; v.xr = xr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input op_t p, input op_t q);
        r1 = p.r; w1 = p.w; b1 = p.b; a1 = p.a; d1 = p.d;
        r2 = q.r; w2 = q.w; b2 = q.b; a2 = q.a; d2 = q.d;
    endtask

    // Called at a negedge; samples one negedge later.
    task automatic run_q(input string tag);
        foreach (tq_v[i]) begin
            drive(tq_v[i].p1, tq_v[i].p2);
            #1;
            chk($sformatf("%s[%0d] gnt1", tag, i), {31'b0, g1}, {31'b0, tq_v[i].p1.r});
            chk($sformatf("%s[%0d] gnt2", tag, i), {31'b0, g2}, {31'b0, tq_v[i].p2.r});
            @(negedge clk);
            chk($sformatf("%s[%0d] rvalid1", tag, i), {31'b0, v1}, {31'b0, tq_v[i].p1.r});
            chk($sformatf("%s[%0d] rvalid2", tag, i), {31'b0, v2}, {31'b0, tq_v[i].p2.r});
            chk($sformatf("%s[%0d] rdata1", tag, i), q1, tq_v[i].x1);
            chk($sformatf("%s[%0d] rdata2", tag, i), q2, tq_v[i].x2);
            chk($sformatf("%s[%0d] mem_flag", tag, i), mf, tq_v[i].xf);
            chk($sformatf("%s[%0d] mem_result", tag, i), mr, tq_v[i].xr);
        end
        drive(NOP(), NOP());
        tq_v.delete();
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        drive(NOP(), NOP());
        tr = 1'b0; tw = 1'b0; ta = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(NOP(), NOP());
        tr = 1'b0; tw = 1'b0; ta = 32'h0;
        #1;
        chk("reset mem_flag", mf, 32'h0);
        chk("reset rvalid1", {31'b0, v1}, 32'h0);
        rst_pulse();

        // Matching results, staggered flags, byte enables, locking
        tq_v.push_back(V(NOP(), NOP(), 0, 0, 0, 0));
        tq_v.push_back(V(WR(RES, 4'b0010, 32'hAABBCCDD), NOP(), 0, 0, 0, 0));
        tq_v.push_back(V(RD(RES), NOP(), 32'h0000CC00, 0, 0, 0));
        tq_v.push_back(V(WR(RES, 4'hF, 42), WR(RES, 4'hF, 42), 0, 0, 0, 0));
        tq_v.push_back(V(WR(FLG, 4'hF, 1), RD(STA), 0, 0, 0, 0));
        tq_v.push_back(V(RD(FLG), RD(STA), 1, 1, 0, 0));
        tq_v.push_back(V(WR(B + 32'h100, 4'hF, 7), RD(STA), 0, 5, 0, 0));
        tq_v.push_back(V(WR(RES, 4'hF, 99), WR(FLG, 4'hF, 1), 0, 0, 0, 0));
        tq_v.push_back(V(RD(RES), NOP(), 42, 0, 1, 42));
        tq_v.push_back(V(NOP(), RD(STA), 0, 11, 1, 42));
        tq_v.push_back(V(RD(CYC), RD(CYC), 8, 8, 1, 42));
        tq_v.push_back(V(RD(B + 32'h100), WR(RES, 4'hF, 7), 0, 0, 1, 42));
        tq_v.push_back(V(NOP(), RD(RES), 0, 42, 1, 42));
        run_q("match");

        // Mismatch with simultaneous flags
        rst_pulse();
        tq_v.push_back(V(WR(RES, 4'hF, 42), WR(RES, 4'hF, 43), 0, 0, 0, 0));
        tq_v.push_back(V(WR(FLG, 4'hF, 1), WR(FLG, 4'hF, 1), 0, 0, 0, 0));
        tq_v.push_back(V(RD(STA), NOP(), 3, 0, 2, 0));
        tq_v.push_back(V(WR(RES, 4'hF, 43), RD(STA), 0, 15, 2, 0));
        tq_v.push_back(V(RD(RES), RD(RES), 42, 43, 2, 0));
        run_q("mismatch");

        // Equal results, simultaneous flags: ONE never visible
        rst_pulse();
        tq_v.push_back(V(WR(RES, 4'hF, 5), WR(RES, 4'hF, 5), 0, 0, 0, 0));
        tq_v.push_back(V(WR(FLG, 4'b0001, 1), WR(FLG, 4'b0001, 1), 0, 0, 0, 0));
        tq_v.push_back(V(RD(STA), NOP(), 3, 0, 1, 5));
        tq_v.push_back(V(NOP(), RD(STA), 0, 11, 1, 5));
        run_q("same");

        // Asynchronous reset out of DONE clears outputs without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst mem_flag", mf, 32'h0);
        chk("async rst mem_result", mr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // One flag set, then reset with a response in flight
        tq_v.push_back(V(WR(RES, 4'hF, 42), NOP(), 0, 0, 0, 0));
        tq_v.push_back(V(WR(FLG, 4'hF, 1), NOP(), 0, 0, 0, 0));
        run_q("pre_rst");
        drive(RD(RES), NOP());
        @(posedge clk);
        #1;
        chk("midrun rvalid1", {31'b0, v1}, 32'h1);
        chk("midrun rdata1", q1, 32'd42);
        rst_n = 1'b0;
        #1;
        chk("rst rvalid1", {31'b0, v1}, 32'h0);
        chk("rst rdata1", q1, 32'h0);
        chk("rst mem_flag", mf, 32'h0);
        chk("rst mem_result", mr, 32'h0);
        @(negedge clk);
        drive(NOP(), NOP());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst rvalid1", {31'b0, v1}, 32'h0);
        tq_v.push_back(V(RD(STA), RD(STA), 0, 0, 0, 0));
        tq_v.push_back(V(RD(FLG), RD(RES), 0, 0, 0, 0));
        run_q("post_rst");

        // Timeout instance (50 cycles)
        rst_pulse();
        repeat (49) @(negedge clk);
        chk("to before", tmf, 32'h0);
        @(negedge clk);
        chk("to flag", tmf, 32'h4);
        chk("to result", tmr, 32'h0);
        tr = 1'b1; tw = 1'b0; ta = CYC;
        @(negedge clk);
        tr = 1'b0;
        chk("to cyc rvalid", {31'b0, tv}, 32'h1);
        chk("to cycles", tq, 32'd49);
        tr = 1'b1; ta = STA;
        @(negedge clk);
        tr = 1'b0;
        chk("to status", tq, 32'h10);
        chk("to flag held", tmf, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

endmodule
